// File: rtl/iter_div_ctrl.sv
// Multi-cycle radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// One trial subtract per cycle; the adder carry-out acts as "no borrow".
// Results are held in DONE until consumed; flush aborts at any point.
module iter_div_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_quot_q, div_quot_d;
  logic [WIDTH-1:0] div_rem_q, div_rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             cout;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] quot_next;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    negate = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand when it is interpreted as signed; raw otherwise.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] sx;
    sx  = x;
    mag = (sgn && (sx < 0)) ? negate(x) : x;
  endfunction

  // Trial subtract of the divisor from the shifted partial remainder.
  // The bit shifted out of prem's MSB is ORed into the carry: if it is set the
  // shifted value is already >= 2**WIDTH > divisor, so no borrow can occur and
  // the low WIDTH bits of the sum are still the exact difference.
  always_comb begin
    shifted   = {prem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    trial     = {1'b0, shifted} + {1'b0, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    cout      = trial[WIDTH] | prem_q[WIDTH-1];
    prem_next = cout ? trial[WIDTH-1:0] : shifted;
    quot_next = {quot_q[WIDTH-2:0], cout};
  end

  // Next-state and datapath update; flush overrides everything else.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_quot_d = div_quot_q;
    div_rem_d  = div_rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    prem_d     = prem_q;
    quot_d     = quot_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (div_valid) begin
          dvd_d      = mag(div_src1, div_signed);
          dvs_d      = mag(div_src2, div_signed);
          neg_quot_d = div_signed & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
          neg_rem_d  = div_signed & div_src1[WIDTH-1];
          prem_d     = '0;
          quot_d     = '0;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        prem_d = prem_next;
        quot_d = quot_next;
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d    = DONE;
          div_quot_d = neg_quot_q ? negate(quot_next) : quot_next;
          div_rem_d  = neg_rem_q ? negate(prem_next) : prem_next;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (div_flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      div_quot_d = div_quot_q;
      div_rem_d  = div_rem_q;
    end
  end

  // Control state and visible results, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_quot_q <= '0;
      div_rem_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_quot_q <= div_quot_d;
      div_rem_q  <= div_rem_d;
    end
  end

  // Iteration datapath; always reloaded on accept, so no reset needed.
  always_ff @(posedge clk) begin
    dvd_q      <= dvd_d;
    dvs_q      <= dvs_d;
    prem_q     <= prem_d;
    quot_q     <= quot_d;
    neg_quot_q <= neg_quot_d;
    neg_rem_q  <= neg_rem_d;
  end

  assign div_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign div_quot  = div_quot_q;
  assign div_rem   = div_rem_q;

endmodule

// File: tb/tb_iter_div_ctrl.sv
// Self-checking bench for iter_div_ctrl: reference results are queued when a
// request is accepted and compared when out_valid rises.
module tb_iter_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic [31:0] div_src1 = '0;
  logic [31:0] div_src2 = '0;
  logic        div_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;
  exp_t sb[$];

  logic prev_ov = 1'b0;

  iter_div_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .div_src1(div_src1), .div_src2(div_src2),
    .div_flush(div_flush), .out_valid(out_valid), .out_ready(out_ready),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference divide following the architectural corner-case rules.
  function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    if (b == 32'd0) begin
      e.q = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'h0;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard: compare each new result against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("quot", div_quot, e.q);
        check("rem", div_rem, e.r);
      end
    end
    prev_ov = out_valid;
  end

  // Present a request and hold it until the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    int n;
    n = 0;
    while (!div_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!div_ready) check("ready_timeout", 32'(div_ready), 32'd1);
    div_src1 = a; div_src2 = b; div_signed = s; div_valid = 1'b1;
    if (push) sb.push_back(ref_div(a, b, s));
    @(posedge clk); #1;
    div_valid = 1'b0;
  endtask

  // Wait for out_valid, returning the number of edges since the accept edge.
  task automatic wait_done(input bit chk_ready, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (chk_ready) check("ready_busy", 32'(div_ready), 32'd0);
    end while (!out_valid && n < 40);
    if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_ov", 32'(out_valid), 32'd0);
    check("consume_rdy", 32'(div_ready), 32'd1);
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    issue(a, b, s, 1'b1);
    wait_done(1'b0, n);
    check("latency", n, 32);
    consume();
  endtask

  initial begin
    int n;
    int ov_seen;
    logic [31:0] hq, hr;

    #1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(div_ready), 32'd1);
    check("rst_quot", div_quot, 32'd0);
    check("rst_rem", div_rem, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 100/7 unsigned with latency and busy checks
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_done(1'b1, n);
    check("latency_100_7", n, 32);
    check("q_100_7", div_quot, 32'h0000_000E);
    check("r_100_7", div_rem, 32'h0000_0002);
    consume();

    run_one(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_one(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_one(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_one(32'd5, 32'd0, 1'b0);
    run_one(32'hFFFF_FFF9, 32'd0, 1'b1);
    run_one(32'd12, 32'd0, 1'b1);
    run_one(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_one(32'd7, 32'hFFFF_FFFE, 1'b1);
    for (int i = 0; i < 6; i++)
      run_one($urandom, $urandom >> $urandom_range(0, 28), 1'($urandom_range(0, 1)));

    // Backpressure in DONE with a competing request
    issue(32'd1000, 32'd10, 1'b0, 1'b1);
    wait_done(1'b0, n);
    hq = div_quot; hr = div_rem;
    div_src1 = 32'd77; div_src2 = 32'd5; div_signed = 1'b0; div_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_rdy", 32'(div_ready), 32'd0);
      check("bp_quot", div_quot, hq);
      check("bp_rem", div_rem, hr);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ov", 32'(out_valid), 32'd0);
    check("bp_release_rdy", 32'(div_ready), 32'd1);
    sb.push_back(ref_div(32'd77, 32'd5, 1'b0));
    @(posedge clk); #1;
    div_valid = 1'b0;
    check("bp_accept", 32'(div_ready), 32'd0);
    wait_done(1'b0, n);
    check("bp_latency", n, 32);
    consume();

    // Flush during iteration
    hq = div_quot; hr = div_rem;
    issue(32'd999, 32'd4, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    check("flush_rdy", 32'(div_ready), 32'd1);
    check("flush_ov", 32'(out_valid), 32'd0);
    ov_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("flush_no_result", ov_seen, 0);
    check("flush_quot_hold", div_quot, hq);
    check("flush_rem_hold", div_rem, hr);

    // Flush coincident with a request in IDLE
    div_src1 = 32'd8; div_src2 = 32'd2; div_valid = 1'b1; div_flush = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0; div_flush = 1'b0;
    check("flush_idle_rdy", 32'(div_ready), 32'd1);

    // Asynchronous reset in the middle of an operation
    issue(32'd50, 32'd7, 1'b0, 1'b0);
    repeat (21) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_rdy", 32'(div_ready), 32'd1);
    check("arst_quot", div_quot, 32'd0);
    check("arst_rem", div_rem, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    wait_done(1'b0, n);
    check("arst_latency", n, 32);
    check("q_9_3", div_quot, 32'd3);
    check("r_9_3", div_rem, 32'd0);
    consume();

    repeat (2) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
